// File: rtl/seq_shift_unit.sv
// Handshaked WIDTH-bit shift engine: load/rotate/logical/arithmetic shifts by a multi-bit amount.
// Define SEQ_SHIFT_FAST_EN to replace the one-bit-per-cycle engine with a single-cycle barrel shifter.
module seq_shift_unit #(
    parameter  int unsigned WIDTH   = 8,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [SHAMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_shout,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ROL  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    state_t               state, state_n;
    logic [WIDTH-1:0]     data, data_n;
    logic                 shout, shout_n;
    logic [SHAMT_W-1:0]   cnt, cnt_n;
    logic [2:0]           op, op_n;
    logic [WIDTH-1:0]     step_data;
    logic                 step_shout;
    logic                 is_shift;

    assign res_data  = data;
    assign res_shout = shout;
    assign is_shift  = (cmd_op >= OP_ROL) && (cmd_op <= OP_ROR);

    // One 1-bit step of the latched op on the current data register
    always_comb begin
        step_data  = data;
        step_shout = 1'b0;
        case (op)
            OP_ROL: begin
                step_data  = {data[WIDTH-2:0], data[WIDTH-1]};
                step_shout = data[WIDTH-1];
            end
            OP_SLL: begin
                step_data  = {data[WIDTH-2:0], 1'b0};
                step_shout = data[WIDTH-1];
            end
            OP_SRL: begin
                step_data  = {1'b0, data[WIDTH-1:1]};
                step_shout = data[0];
            end
            OP_SRA: begin
                step_data  = {data[WIDTH-1], data[WIDTH-1:1]};
                step_shout = data[0];
            end
            OP_ROR: begin
                step_data  = {data[0], data[WIDTH-1:1]};
                step_shout = data[0];
            end
            default: begin
                step_data  = data;
                step_shout = 1'b0;
            end
        endcase
    end

`ifdef SEQ_SHIFT_FAST_EN
    logic [WIDTH-1:0]   fast_data;
    logic               fast_shout;
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
    logic [SHAMT_W-1:0] left_idx, right_idx;

    // Full-amount result in one cycle; shout is the last bit the iterative engine would drop
    always_comb begin
        dbl_l      = {data, data} << cmd_amt;
        dbl_r      = {data, data} >> cmd_amt;
        left_idx   = SHAMT_W'(WIDTH - 32'(cmd_amt));
        right_idx  = cmd_amt - SHAMT_W'(1);
        fast_data  = data;
        fast_shout = 1'b0;
        case (cmd_op)
            OP_ROL: begin
                fast_data  = dbl_l[2*WIDTH-1:WIDTH];
                fast_shout = data[left_idx];
            end
            OP_SLL: begin
                fast_data  = data << cmd_amt;
                fast_shout = data[left_idx];
            end
            OP_SRL: begin
                fast_data  = data >> cmd_amt;
                fast_shout = data[right_idx];
            end
            OP_SRA: begin
                fast_data  = WIDTH'($signed(data) >>> cmd_amt);
                fast_shout = data[right_idx];
            end
            OP_ROR: begin
                fast_data  = dbl_r[WIDTH-1:0];
                fast_shout = data[right_idx];
            end
            default: begin
                fast_data  = data;
                fast_shout = 1'b0;
            end
        endcase
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        data_n  = data;
        shout_n = shout;
        cnt_n   = cnt;
        op_n    = op;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    shout_n = 1'b0;
                    state_n = DONE;
                    if (cmd_op == OP_LOAD) begin
                        data_n = cmd_data;
                    end else if (is_shift && (cmd_amt != '0)) begin
`ifdef SEQ_SHIFT_FAST_EN
                        data_n  = fast_data;
                        shout_n = fast_shout;
`else
                        op_n    = cmd_op;
                        cnt_n   = cmd_amt;
                        state_n = SHIFT;
`endif
                    end
                end
            end
            SHIFT: begin
                data_n  = step_data;
                shout_n = step_shout;
                cnt_n   = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; flags are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            data      <= '0;
            shout     <= 1'b0;
            cnt       <= '0;
            op        <= OP_LOAD;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            data      <= data_n;
            shout     <= shout_n;
            cnt       <= cnt_n;
            op        <= op_n;
            cmd_ready <= (state_n == IDLE);
            res_valid <= (state_n == DONE);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit (WIDTH=8): directed commands, literal expectations, per-cycle model compare.
module tb_seq_shift_unit;

    localparam int unsigned W = 8;
`ifdef SEQ_SHIFT_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [2:0]   cmd_amt = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_shout;
    logic         busy;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    seq_shift_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_shout(res_shout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Final {shout, data} of a whole command, computed arithmetically from the op definitions
    function automatic logic [8:0] ref_op(input logic [2:0] op, input int n,
                                          input logic [7:0] d, input logic [7:0] ld);
        int v;
        int sv;
        int r;
        int s;
        v = int'(d);
        r = v;
        s = 0;
        if (op == 3'd0) begin
            r = int'(ld);
        end else if (op <= 3'd5 && n > 0) begin
            case (op)
                3'd1: begin r = ((v << n) | (v >> (8 - n))) & 255; s = (v >> (8 - n)) & 1; end
                3'd2: begin r = (v << n) & 255;                     s = (v >> (8 - n)) & 1; end
                3'd3: begin r = v >> n;                             s = (v >> (n - 1)) & 1; end
                3'd4: begin
                    sv = (v >= 128) ? v - 256 : v;
                    r  = (sv >>> n) & 255;
                    s  = (v >> (n - 1)) & 1;
                end
                default: begin r = ((v >> n) | (v << (8 - n))) & 255; s = (v >> (n - 1)) & 1; end
            endcase
        end
        return {s[0], r[7:0]};
    endfunction

    function automatic int lat_of(input logic [2:0] op, input int n);
        if (!FAST && op >= 3'd1 && op <= 3'd5 && n > 0) return n + 1;
        return 1;
    endfunction

    // Transaction-level model: idle / counting down steps / result pending
    bit         m_idle = 1'b1;
    int         m_left = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    bit         m_shout = 1'b0;

    always @(posedge clk) begin
        logic [8:0] r;
        if (reset) begin
            m_idle = 1'b1; m_left = 0; m_valid = 1'b0; m_data = '0; m_shout = 1'b0;
        end else if (m_valid) begin
            if (res_ready) begin
                m_valid = 1'b0;
                m_idle  = 1'b1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (m_idle && cmd_valid) begin
            r       = ref_op(cmd_op, int'(cmd_amt), m_data, cmd_data);
            m_data  = r[7:0];
            m_shout = r[8];
            m_idle  = 1'b0;
            if (lat_of(cmd_op, int'(cmd_amt)) == 1) m_valid = 1'b1;
            else m_left = int'(cmd_amt);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_cmd_ready", 32'(cmd_ready), 32'(m_idle));
            check("cyc_busy", 32'(busy), 32'(!m_idle));
            check("cyc_res_valid", 32'(res_valid), 32'(m_valid));
            if (m_left == 0) begin
                check("cyc_res_data", 32'(res_data), 32'(m_data));
                check("cyc_res_shout", 32'(res_shout), 32'(m_shout));
            end
        end
    end

    task automatic do_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d,
                          input logic [7:0] ed, input bit es, input int elat, input string tag);
        int lat;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = d;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_data"}, 32'(res_data), 32'(ed));
        check({tag, "_shout"}, 32'(res_shout), 32'(es));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);

        do_cmd(3'd0, 3'd0, 8'hA5, 8'hA5, 1'b0, 1, "load_a5");
        do_cmd(3'd1, 3'd3, 8'h00, 8'h2D, 1'b1, FAST ? 1 : 4, "rol3");
        do_cmd(3'd0, 3'd0, 8'h90, 8'h90, 1'b0, 1, "load_90");
        do_cmd(3'd4, 3'd2, 8'h00, 8'hE4, 1'b0, FAST ? 1 : 3, "sra2");
        do_cmd(3'd0, 3'd0, 8'h81, 8'h81, 1'b0, 1, "load_81a");
        do_cmd(3'd3, 3'd7, 8'h00, 8'h01, 1'b0, FAST ? 1 : 8, "srl7");
        do_cmd(3'd0, 3'd0, 8'h81, 8'h81, 1'b0, 1, "load_81b");
        do_cmd(3'd2, 3'd1, 8'h00, 8'h02, 1'b1, FAST ? 1 : 2, "sll1");
        do_cmd(3'd2, 3'd0, 8'h00, 8'h02, 1'b0, 1, "sll0");
        do_cmd(3'd5, 3'd1, 8'h00, 8'h01, 1'b0, FAST ? 1 : 2, "ror1a");
        do_cmd(3'd5, 3'd1, 8'h00, 8'h80, 1'b1, FAST ? 1 : 2, "ror1b");
        do_cmd(3'd6, 3'd5, 8'h55, 8'h80, 1'b0, 1, "hold");
        do_cmd(3'd4, 3'd7, 8'h00, 8'hFF, 1'b0, FAST ? 1 : 8, "sra7");
        do_cmd(3'd1, 3'd7, 8'h00, 8'hFF, 1'b1, FAST ? 1 : 8, "rol7");

        // Result held while consumer stalls; commands pulsed meanwhile must be ignored
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 8'h33;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = i[0]; cmd_op = 3'd0; cmd_data = 8'h11;
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_data", 32'(res_data), 32'h33);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset in the third SHIFT cycle aborts the rotate
        do_cmd(3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 1, "load_ff");
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_amt = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_res_data", 32'(res_data), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);

        do_cmd(3'd1, 3'd1, 8'h00, 8'h00, 1'b0, FAST ? 1 : 2, "rol_after_rst");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
